// File: rtl/exe_md_unit.sv
// rtl/exe_md_unit.sv - execute stage: registered ALU plus iterative multiply/divide
module exe_md_unit #(
  parameter int XLEN  = 64,
  parameter int MD_EN = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op_i,
  input  logic            use_imm_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic            flush_i,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] res_o,
  output logic [XLEN-1:0] pc_o,
  output logic            err_o
);
  localparam int SHW = $clog2(XLEN);

  localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_SLL = 5'd2,  OP_SLT = 5'd3;
  localparam logic [4:0] OP_SLTU = 5'd4, OP_XOR = 5'd5,  OP_SRL = 5'd6,  OP_SRA = 5'd7;
  localparam logic [4:0] OP_OR = 5'd8,   OP_AND = 5'd9,  OP_MUL = 5'd10, OP_MULH = 5'd11;
  localparam logic [4:0] OP_MULHSU = 5'd12, OP_MULHU = 5'd13, OP_DIV = 5'd14, OP_DIVU = 5'd15;
  localparam logic [4:0] OP_REM = 5'd16, OP_REMU = 5'd17;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic [4:0]      op_q, op_d;
  logic            neg_q, neg_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, opb_q, opb_d;
  logic [XLEN-1:0] res_q, res_d, pc_q, pc_d;
  logic            err_q, err_d;

  logic [XLEN-1:0] opa, opb, alu_res, mag_a, mag_b;
  logic [SHW-1:0]  shamt;
  logic            sgn_a, sgn_b, is_md, accept;

  logic [XLEN:0]     mul_sum, div_sh;
  logic [XLEN+1:0]   div_diff;
  logic [XLEN-1:0]   step_hi, step_lo, md_res;
  logic [2*XLEN-1:0] prod;
  logic              div_op;

  // Operand select, single-cycle ALU result and operand magnitudes for M ops
  always_comb begin
    opa     = src1_i;
    opb     = use_imm_i ? imm_i : src2_i;
    shamt   = opb[SHW-1:0];
    alu_res = '0;
    case (op_i)
      OP_ADD:  alu_res = opa + opb;
      OP_SUB:  alu_res = opa - opb;
      OP_SLL:  alu_res = opa << shamt;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(opa) < $signed(opb)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, opa < opb};
      OP_XOR:  alu_res = opa ^ opb;
      OP_SRL:  alu_res = opa >> shamt;
      OP_SRA:  alu_res = $signed(opa) >>> shamt;
      OP_OR:   alu_res = opa | opb;
      OP_AND:  alu_res = opa & opb;
      default: alu_res = '0;
    endcase
    is_md = (op_i >= OP_MUL) && (op_i <= OP_REMU);
    sgn_a = opa[XLEN-1] && ((op_i == OP_MULH) || (op_i == OP_MULHSU) ||
                            (op_i == OP_DIV)  || (op_i == OP_REM));
    sgn_b = opb[XLEN-1] && ((op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM));
    mag_a = sgn_a ? -opa : opa;
    mag_b = sgn_b ? -opb : opb;
  end

  // One shift-add or restoring-subtract step, plus the sign-corrected final result
  always_comb begin
    div_op   = (op_q >= OP_DIV);
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    div_sh   = {hi_q, lo_q[XLEN-1]};
    div_diff = {1'b0, div_sh} - {2'b00, opb_q};
    if (div_op) begin
      if (!div_diff[XLEN+1]) begin
        step_hi = XLEN'(div_diff);
        step_lo = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        step_hi = XLEN'(div_sh);
        step_lo = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
    end
    prod = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};
    case (op_q)
      OP_MUL:                       md_res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: md_res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              md_res = neg_q ? -step_lo : step_lo;
      default:                      md_res = neg_q ? -step_hi : step_hi;
    endcase
  end

  // Handshake, next state and datapath register updates; flush overrides the state
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    neg_d     = neg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opb_d     = opb_q;
    res_d     = res_q;
    pc_d      = pc_q;
    err_d     = err_q;
    in_ready  = !flush_i && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    out_valid = (state_q == DONE);
    accept    = in_valid && in_ready;
    case (state_q)
      BUSY: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SHW'(XLEN-1)) begin
          state_d = DONE;
          res_d   = md_res;
          err_d   = 1'b0;
        end
      end
      DONE:    if (out_ready) state_d = IDLE;
      default: ;
    endcase
    if (accept) begin
      op_d = op_i;
      pc_d = pc_i;
      if (is_md && (MD_EN != 0)) begin
        state_d = BUSY;
        cnt_d   = '0;
        hi_d    = '0;
        lo_d    = mag_a;
        opb_d   = mag_b;
        // Quotient stays all ones on divide by zero; remainder follows the dividend
        if (op_i == OP_REM)      neg_d = sgn_a;
        else if (op_i == OP_DIV) neg_d = (sgn_a ^ sgn_b) && (opb != '0);
        else                     neg_d = sgn_a ^ sgn_b;
      end else begin
        state_d = DONE;
        err_d   = (op_i > OP_AND);
        res_d   = (op_i > OP_AND) ? '0 : alu_res;
      end
    end
    if (flush_i) state_d = IDLE;
  end

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      pc_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
    end
  end

  assign res_o = res_q;
  assign pc_o  = pc_q;
  assign err_o = err_q;

endmodule
